// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - cache-to-SRAM responder: 32-bit writes and 64-bit block reads over a 16-bit async SRAM
//
// Ports:
//   clk, rst          system clock (rising edge), asynchronous active-high reset
//   address[31:0]     byte address; only [18:1] reach the SRAM (512 KB wrap)
//   wdata[31:0]       write data
//   wr_en, rd_en      level requests held until ready; write wins when both are high
//   rdata[63:0]       read block {word@+4, word@+0}; holds until the next read beat
//   ready             one-cycle completion pulse
//   SRAM_DQ[15:0]     SRAM data bus, driven only while writing
//   SRAM_ADDR[17:0]   SRAM halfword address
//   SRAM_WE_N, SRAM_OE_N            active-low write/output enables
//   SRAM_CE_N, SRAM_UB_N, SRAM_LB_N tied low
//
// Optional feature: define SRAM_CTRL_LINE_BUFFER_EN for a one-entry read line buffer.

module sram_controller #(
   parameter int ACCESS_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] address,
   input  logic [31:0] wdata,
   input  logic        wr_en,
   input  logic        rd_en,
   output logic [63:0] rdata,
   output logic        ready,
   inout  wire  [15:0] SRAM_DQ,
   output logic [17:0] SRAM_ADDR,
   output logic        SRAM_WE_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_CE_N,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [3:0] LAST_CYC = 4'(ACCESS_CYCLES - 1);

   state_t      state, state_nxt;
   logic [3:0]  cyc;
   logic [1:0]  beat;
   logic [18:2] addr_q;
   logic [31:0] wdata_q;
   logic        last_cyc;
   logic        dq_oe;
   logic [15:0] dq_out;
   logic        lb_hit;
   logic        unused_addr_bits;

   assign last_cyc         = (cyc == LAST_CYC);
   assign unused_addr_bits = ^{address[31:19], address[1:0]};

   assign SRAM_CE_N = 1'b0;
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;
   assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;

`ifdef SRAM_CTRL_LINE_BUFFER_EN
   // Only the tag is stored: while valid, rdata still holds the buffered block,
   // because rdata changes only on read beats and every read that starts either
   // completes (refreshing the tag) or is aborted by rst (clearing valid).
   logic        lb_valid;
   logic [18:3] lb_tag;

   assign lb_hit = lb_valid && (address[18:3] == lb_tag);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lb_valid <= 1'b0;
         lb_tag   <= '0;
      end else if (state == IDLE && wr_en) begin
         if (address[18:3] == lb_tag)
            lb_valid <= 1'b0;
      end else if (state == RD && last_cyc && beat == 2'd3) begin
         lb_valid <= 1'b1;
         lb_tag   <= addr_q[18:3];
      end
   end
`else
   assign lb_hit = 1'b0;
`endif

   // State register, beat/cycle counters, request latch and read capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cyc     <= '0;
         beat    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata   <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               cyc  <= '0;
               beat <= '0;
               if (wr_en || rd_en) begin
                  addr_q  <= address[18:2];
                  wdata_q <= wdata;
               end
            end
            WR, RD: begin
               if (last_cyc) begin
                  cyc  <= '0;
                  beat <= beat + 2'd1;
               end else begin
                  cyc <= cyc + 4'd1;
               end
               // SRAM output has settled by the last cycle of the beat
               if (state == RD && last_cyc)
                  rdata[{beat, 4'b0000} +: 16] <= SRAM_DQ;
            end
            default: begin
               cyc  <= '0;
               beat <= '0;
            end
         endcase
      end
   end

   // Next state and SRAM strobes
   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      SRAM_ADDR = '0;
      SRAM_WE_N = 1'b1;
      SRAM_OE_N = 1'b1;
      dq_oe     = 1'b0;
      dq_out    = '0;
      case (state)
         IDLE: begin
            if (wr_en)
               state_nxt = WR;
            else if (rd_en)
               state_nxt = lb_hit ? DONE : RD;
         end
         WR: begin
            SRAM_ADDR = {addr_q[18:2], beat[0]};
            dq_oe     = 1'b1;
            dq_out    = beat[0] ? wdata_q[31:16] : wdata_q[15:0];
            // WE_N rises in the last cycle so ADDR/DQ stay stable past the write edge
            SRAM_WE_N = last_cyc;
            if (last_cyc && beat == 2'd1)
               state_nxt = DONE;
         end
         RD: begin
            SRAM_ADDR = {addr_q[18:3], beat};
            SRAM_OE_N = 1'b0;
            if (last_cyc && beat == 2'd3)
               state_nxt = DONE;
         end
         DONE: begin
            ready     = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - scoreboard bench for sram_controller with async SRAM model
module tb_sram_controller;

   localparam int AC = 2;

`ifdef SRAM_CTRL_LINE_BUFFER_EN
   localparam bit LB_EN = 1'b1;
`else
   localparam bit LB_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] address = '0;
   logic [31:0] wdata = '0;
   logic        wr_en = 1'b0;
   logic        rd_en = 1'b0;
   logic [63:0] rdata;
   logic        ready;
   wire  [15:0] sram_dq;
   logic [17:0] sram_addr;
   logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

   sram_controller #(.ACCESS_CYCLES(AC)) dut (
      .clk(clk), .rst(rst), .address(address), .wdata(wdata),
      .wr_en(wr_en), .rd_en(rd_en), .rdata(rdata), .ready(ready),
      .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(sram_we_n),
      .SRAM_OE_N(sram_oe_n), .SRAM_CE_N(sram_ce_n), .SRAM_UB_N(sram_ub_n),
      .SRAM_LB_N(sram_lb_n)
   );

   always #5 clk = ~clk;

   // Asynchronous SRAM: write while WE_N low, drive bus while OE_N low and WE_N high
   logic [15:0] sram_mem [0:262143];
   assign sram_dq = (!sram_oe_n && sram_we_n) ? sram_mem[sram_addr] : 16'hzzzz;

   initial begin
      for (int i = 0; i < 262144; i++) sram_mem[i] = 16'h0000;
      forever begin
         @(sram_we_n or sram_addr or sram_dq);
         if (sram_we_n == 1'b0) sram_mem[sram_addr] = sram_dq;
      end
   end

   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference model: halfword memory plus line-buffer bookkeeping
   typedef struct {
      string       name;
      int          issue;
      int          lat;
      logic [63:0] rdata;
      int          we;
      int          oe;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] ref_mem [int];
   logic [63:0] last_rd = '0;
   bit          lb_valid = 1'b0;
   logic [15:0] lb_tag = '0;

   function automatic logic [15:0] m_rd(input int hw);
      return ref_mem.exists(hw) ? ref_mem[hw] : 16'h0000;
   endfunction

   task automatic model_txn(input string nm, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input int issue, output exp_t e);
      int  hw;
      bit  hit;
      e.name  = nm;
      e.issue = issue;
      if (w) begin
         hw = int'(a[18:2]) * 2;
         ref_mem[hw]     = d[15:0];
         ref_mem[hw + 1] = d[31:16];
         e.lat   = 2 * AC + 1;
         e.we    = 2;
         e.oe    = 0;
         e.rdata = last_rd;
         if (LB_EN && lb_valid && a[18:3] == lb_tag) lb_valid = 1'b0;
      end else begin
         hw  = int'(a[18:3]) * 4;
         hit = LB_EN && lb_valid && a[18:3] == lb_tag;
         e.rdata = {m_rd(hw + 3), m_rd(hw + 2), m_rd(hw + 1), m_rd(hw)};
         last_rd = e.rdata;
         e.lat   = hit ? 1 : 4 * AC + 1;
         e.we    = 0;
         e.oe    = hit ? 0 : 4 * AC;
         if (!hit) begin
            lb_valid = 1'b1;
            lb_tag   = a[18:3];
         end
      end
   endtask

   // Monitor: strobe accounting and scoreboard compare on each ready pulse
   int  we_falls = 0;
   int  oe_cycles = 0;
   bit  prev_we = 1'b1;

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            we_falls  = 0;
            oe_cycles = 0;
            prev_we   = 1'b1;
         end else begin
            if (prev_we && !sram_we_n) we_falls++;
            prev_we = sram_we_n;
            if (!sram_oe_n) oe_cycles++;
            if (ready) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_ready: got ready=1 at cycle %0d expected no pulse", cyc_cnt);
               end else begin
                  e = sb.pop_front();
                  check({e.name, "_latency"}, 64'(cyc_cnt - e.issue + 1), 64'(e.lat));
                  check({e.name, "_rdata"}, rdata, e.rdata);
                  check({e.name, "_we_pulses"}, 64'(we_falls), 64'(e.we));
                  check({e.name, "_oe_cycles"}, 64'(oe_cycles), 64'(e.oe));
               end
               we_falls  = 0;
               oe_cycles = 0;
            end
         end
      end
   end

   task automatic wait_ready(input string nm);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ready && n < 100);
      if (!ready) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no ready after %0d cycles expected a pulse", nm, n);
         sb.delete();
      end
   endtask

   // Issue one transaction, scramble inputs after the latch edge, wait for ready
   task automatic do_txn(input string nm, input logic w, input logic r,
                         input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      @(negedge clk);
      model_txn(nm, w, a, d, cyc_cnt + 1, e);
      sb.push_back(e);
      address = a;
      wdata   = d;
      wr_en   = w;
      rd_en   = r;
      @(negedge clk);
      address = $urandom;
      wdata   = $urandom;
      if (!ready) wait_ready(nm);
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   initial begin
      exp_t        e;
      logic [31:0] a, d;
      int          op;

      repeat (3) @(negedge clk);
      check("reset_ready", 64'(ready), 64'(0));
      check("reset_rdata", rdata, 64'(0));
      check("reset_we_n", 64'(sram_we_n), 64'(1));
      check("reset_oe_n", 64'(sram_oe_n), 64'(1));
      check("reset_addr", 64'(sram_addr), 64'(0));
      rst = 1'b0;

      do_txn("t1_write", 1'b1, 1'b0, 32'h0000_0404, 32'hDEAD_BEEF);
      check("t1_sram_202", 64'(sram_mem[18'h202]), 64'hBEEF);
      check("t1_sram_203", 64'(sram_mem[18'h203]), 64'hDEAD);

      do_txn("t2_wr_a", 1'b1, 1'b0, 32'h0000_0400, 32'h1111_1111);
      do_txn("t2_wr_b", 1'b1, 1'b0, 32'h0000_0404, 32'h2222_2222);
      do_txn("t2_read", 1'b0, 1'b1, 32'h0000_0404, 32'h0);
      do_txn("t3_both", 1'b1, 1'b1, 32'h0000_0408, 32'hCAFE_F00D);

      // Random mix over a small window so reads see earlier writes; upper bits exercise the wrap
      for (int i = 0; i < 40; i++) begin
         op = $urandom_range(0, 2);
         a  = ($urandom & 32'hFFF8_0000) | 32'h400 | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
         d  = $urandom;
         do_txn($sformatf("rnd%0d", i), op != 1, op != 0, a, d);
      end

      // Held rd_en: two pulses one cycle wide with one IDLE cycle between
      @(negedge clk);
      model_txn("t4_first", 1'b0, 32'h0000_0410, 32'h0, cyc_cnt + 1, e);
      sb.push_back(e);
      address = 32'h0000_0410;
      rd_en   = 1'b1;
      wait_ready("t4_first");
      model_txn("t4_second", 1'b0, 32'h0000_0410, 32'h0, cyc_cnt + 2, e);
      sb.push_back(e);
      @(negedge clk);
      check("t4_pulse_width", 64'(ready), 64'(0));
      wait_ready("t4_second");
      rd_en = 1'b0;

      // Reset in cycle 4 of a read; the write first evicts any buffered copy
      do_txn("t5_prep", 1'b1, 1'b0, 32'h0000_0500, 32'h5A5A_A5A5);
      @(negedge clk);
      model_txn("t5_aborted", 1'b0, 32'h0000_0500, 32'h0, cyc_cnt + 1, e);
      address = 32'h0000_0500;
      rd_en   = 1'b1;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("t5_oe_n", 64'(sram_oe_n), 64'(1));
      check("t5_we_n", 64'(sram_we_n), 64'(1));
      check("t5_ready", 64'(ready), 64'(0));
      check("t5_rdata", rdata, 64'(0));
      lb_valid = 1'b0;
      last_rd  = '0;
      rd_en    = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      do_txn("t5_read", 1'b0, 1'b1, 32'h0000_0500, 32'h0);

`ifdef SRAM_CTRL_LINE_BUFFER_EN
      do_txn("t6_read1", 1'b0, 1'b1, 32'h0000_0400, 32'h0);
      do_txn("t6_read2", 1'b0, 1'b1, 32'h0000_0400, 32'h0);
      do_txn("t6_write", 1'b1, 1'b0, 32'h0000_0404, 32'h3333_4444);
      do_txn("t6_read3", 1'b0, 1'b1, 32'h0000_0400, 32'h0);
`endif

      repeat (4) @(negedge clk);
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
